// File: rtl/stft_framer.sv
// STFT framer: pops PCM samples from the width-converting FIFO into a circular
// buffer and streams overlapping frames, oldest sample first, on valid/ready.
module stft_framer #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAME_LEN  = 512,
   parameter int HOP_LEN    = 128,
   parameter int ADDR_WIDTH = $clog2(FRAME_LEN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [ADDR_WIDTH-1:0] m_index,
   output logic                  m_last,
   output logic [15:0]           frame_cnt
);

   generate
      if (FRAME_LEN < 2 || (FRAME_LEN & (FRAME_LEN - 1)) != 0)
         $error("stft_framer: FRAME_LEN must be a power of two >= 2");
      if (HOP_LEN < 1 || HOP_LEN > FRAME_LEN)
         $error("stft_framer: HOP_LEN must be in 1..FRAME_LEN");
   endgenerate

   localparam logic [0:0] S_FILL = 1'b0;
   localparam logic [0:0] S_EMIT = 1'b1;

   localparam logic [ADDR_WIDTH:0]   NEED_FIRST = (ADDR_WIDTH+1)'(FRAME_LEN);
   localparam logic [ADDR_WIDTH:0]   NEED_HOP   = (ADDR_WIDTH+1)'(HOP_LEN);
   localparam logic [ADDR_WIDTH-1:0] IDX_LAST   = ADDR_WIDTH'(FRAME_LEN - 1);

   logic [DATA_WIDTH-1:0] ring [FRAME_LEN];

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] wr_ptr_nxt;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ADDR_WIDTH:0]   fill_cnt;
   logic [ADDR_WIDTH:0]   fill_nxt;
   logic [ADDR_WIDTH:0]   need;
   logic                  pop;
   logic                  hs;

   assign pop        = (state == S_FILL) && !fifo_empty && !clr;
   assign fifo_rd_en = pop;
   assign wr_ptr_nxt = wr_ptr + ADDR_WIDTH'(1);
   assign fill_nxt   = fill_cnt + (ADDR_WIDTH+1)'(1);

   assign m_valid = (state == S_EMIT);
   assign m_last  = m_valid && (m_index == IDX_LAST);
   assign hs      = m_valid && m_ready;

   // Power-of-two ring: the address sum wraps for free.
   assign rd_addr = base + m_index;
   assign m_data  = ring[rd_addr];

   // Ring storage is deliberately left out of reset/clr.
   always_ff @(posedge clk) begin
      if (pop)
         ring[wr_ptr] <= fifo_rd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FILL;
         wr_ptr    <= '0;
         base      <= '0;
         fill_cnt  <= '0;
         need      <= NEED_FIRST;
         m_index   <= '0;
         frame_cnt <= '0;
      end else if (clr) begin
         state     <= S_FILL;
         wr_ptr    <= '0;
         base      <= '0;
         fill_cnt  <= '0;
         need      <= NEED_FIRST;
         m_index   <= '0;
         frame_cnt <= '0;
      end else begin
         case (state)
            S_FILL: begin
               if (pop) begin
                  wr_ptr <= wr_ptr_nxt;
                  // After the first frame only HOP_LEN fresh samples are required.
                  if (fill_nxt == need) begin
                     state    <= S_EMIT;
                     fill_cnt <= '0;
                     need     <= NEED_HOP;
                     base     <= wr_ptr_nxt;
                  end else begin
                     fill_cnt <= fill_nxt;
                  end
               end
            end
            default: begin
               if (hs) begin
                  if (m_index == IDX_LAST) begin
                     m_index   <= '0;
                     frame_cnt <= frame_cnt + 16'd1;
                     state     <= S_FILL;
                  end else begin
                     m_index <= m_index + ADDR_WIDTH'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stft_framer.sv
// Directed bench for stft_framer: FRAME_LEN=8 with HOP_LEN=4 (dut_a) and
// HOP_LEN=8 (dut_b), each fed by a small FIFO model.
module tb_stft_framer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   // FIFO models
   logic [15:0] mem_a [0:255];
   logic [15:0] mem_b [0:255];
   int head_a = 0, tail_a = 0, head_b = 0, tail_b = 0;

   logic        fe_a, ren_a, mv_a, ml_a, fe_b, ren_b, mv_b, ml_b;
   logic        mr_a = 1'b1;
   logic        mr_b = 1'b1;
   logic [15:0] frd_a, frd_b, md_a, md_b, fc_a, fc_b;
   logic [2:0]  mi_a, mi_b;

   assign fe_a  = (head_a == tail_a);
   assign fe_b  = (head_b == tail_b);
   assign frd_a = mem_a[head_a[7:0]];
   assign frd_b = mem_b[head_b[7:0]];

   always @(posedge clk) begin
      if (ren_a) head_a <= head_a + 1;
      if (ren_b) head_b <= head_b + 1;
   end

   stft_framer #(.DATA_WIDTH(16), .FRAME_LEN(8), .HOP_LEN(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .fifo_empty(fe_a), .fifo_rd_data(frd_a), .fifo_rd_en(ren_a),
      .m_valid(mv_a), .m_ready(mr_a), .m_data(md_a), .m_index(mi_a),
      .m_last(ml_a), .frame_cnt(fc_a));

   stft_framer #(.DATA_WIDTH(16), .FRAME_LEN(8), .HOP_LEN(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .fifo_empty(fe_b), .fifo_rd_data(frd_b), .fifo_rd_en(ren_b),
      .m_valid(mv_b), .m_ready(mr_b), .m_data(md_b), .m_index(mi_b),
      .m_last(ml_b), .frame_cnt(fc_b));

   function automatic logic [31:0] pk(input logic [15:0] d, input logic [2:0] i, input logic l);
      return {7'd0, l, 5'd0, i, d};
   endfunction

   // Monitor: captures accepted samples and protocol properties at negedge.
   logic [31:0] cap_a [$];
   logic [31:0] cap_b [$];
   int cyc = 0, last_pop = 0, first_gap = -1, rd_viol = 0, stab_err = 0;
   logic        prev_v = 1'b0, prev_stall = 1'b0;
   logic [15:0] prev_d = '0;
   logic [2:0]  prev_i = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ren_a) last_pop = cyc;
      if (mv_a && !prev_v && first_gap < 0) first_gap = cyc - last_pop;
      if (mv_a && ren_a) rd_viol++;
      if (prev_stall && (!mv_a || md_a != prev_d || mi_a != prev_i)) stab_err++;
      if (mv_a && mr_a) cap_a.push_back(pk(md_a, mi_a, ml_a));
      if (mv_b && mr_b) cap_b.push_back(pk(md_b, mi_b, ml_b));
      prev_v     = mv_a;
      prev_stall = mv_a && !mr_a;
      prev_d     = md_a;
      prev_i     = mi_a;
   end

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input int v);
      mem_a[tail_a[7:0]] = 16'(v);
      tail_a++;
   endtask

   task automatic push_b(input int v);
      mem_b[tail_b[7:0]] = 16'(v);
      tail_b++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr   = 1'b0;
      mr_a  = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      cap_a.delete();
      cap_b.delete();
   endtask

   task automatic wait_fa(input string tag, input int n);
      int k = 0;
      while (fc_a != 16'(n) && k < 400) begin tick(); k++; end
      chk(tag, {16'd0, fc_a}, n);
   endtask

   // Expected: frame f, position i carries first + hop*f + i.
   task automatic chk_seq(input string tag, input bit use_b, input int first, input int hop, input int nfr);
      int sz;
      logic [31:0] got;
      sz = use_b ? cap_b.size() : cap_a.size();
      chk({tag, "_count"}, sz, nfr * 8);
      for (int f = 0; f < nfr; f++)
         for (int i = 0; i < 8; i++) begin
            int k = f * 8 + i;
            if (k < sz) got = use_b ? cap_b[k] : cap_a[k];
            else        got = 32'hdead_beef;
            chk(tag, got, pk(16'(first + hop * f + i), 3'(i), i == 7));
         end
   endtask

   initial begin
      int k, nv;
      logic [3:0] pat;
      bit found;

      // Reset state, then basic overlap framing
      do_reset();
      chk("rst_valid", mv_a, 0);
      chk("rst_last", ml_a, 0);
      chk("rst_rden", ren_a, 0);
      chk("rst_fcnt", fc_a, 0);
      chk("rst_index", mi_a, 0);
      for (int v = 1; v <= 16; v++) push_a(v);
      wait_fa("basic_wait", 3);
      chk_seq("basic", 1'b0, 1, 4, 3);
      chk("valid_latency", first_gap, 1);
      chk("rden_in_emit", rd_viol, 0);
      repeat (3) tick();
      chk("basic_fcnt", fc_a, 3);

      // Backpressure 1,0,0,1
      do_reset();
      for (int v = 21; v <= 28; v++) push_a(v);
      pat = 4'b1001;
      k = 0;
      while (fc_a != 16'd1 && k < 200) begin
         mr_a = pat[k % 4];
         tick();
         k++;
      end
      mr_a = 1'b1;
      chk("bp_wait", fc_a, 1);
      chk_seq("bp", 1'b0, 21, 4, 1);
      chk("bp_stable", stab_err, 0);

      // FIFO starvation after 5 samples
      do_reset();
      for (int v = 31; v <= 35; v++) push_a(v);
      nv = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (mv_a) nv++;
      end
      chk("starve_novalid", nv, 0);
      chk("starve_fill", {28'd0, dut_a.fill_cnt}, 5);
      for (int v = 36; v <= 38; v++) push_a(v);
      wait_fa("starve_wait", 1);
      chk_seq("starve", 1'b0, 31, 4, 1);

      // clr at m_index=3 of frame 1
      do_reset();
      for (int v = 41; v <= 52; v++) push_a(v);
      k = 0;
      found = 0;
      while (!found && k < 200) begin
         tick();
         k++;
         if (mv_a && mi_a == 3'd3 && fc_a == 16'd1) found = 1;
      end
      chk("clr_found", found, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_valid", mv_a, 0);
      chk("clr_fcnt", fc_a, 0);
      chk("clr_need", {28'd0, dut_a.need}, 8);
      cap_a.delete();
      for (int v = 100; v <= 107; v++) push_a(v);
      wait_fa("clr_wait", 1);
      chk_seq("clr_frame", 1'b0, 100, 4, 1);

      // HOP_LEN == FRAME_LEN on dut_b
      for (int v = 1; v <= 16; v++) push_b(v);
      k = 0;
      while (fc_b != 16'd2 && k < 400) begin tick(); k++; end
      chk("hop8_wait", fc_b, 2);
      chk_seq("hop8", 1'b1, 1, 8, 2);

      // Async reset mid-FILL drops the partial frame
      do_reset();
      for (int v = 60; v <= 62; v++) push_a(v);
      repeat (6) tick();
      chk("pre_rst_fill", {28'd0, dut_a.fill_cnt}, 3);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", mv_a, 0);
      chk("arst_last", ml_a, 0);
      chk("arst_rden", ren_a, 0);
      chk("arst_fcnt", fc_a, 0);
      chk("arst_index", mi_a, 0);
      chk("arst_need", {28'd0, dut_a.need}, 8);
      chk("arst_fill", {28'd0, dut_a.fill_cnt}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      cap_a.delete();
      for (int v = 200; v <= 207; v++) push_a(v);
      wait_fa("arst_wait", 1);
      chk_seq("arst_frame", 1'b0, 200, 4, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/stft_framer.md
Name: stft_framer

Overview:
- Downstream consumer of the width-converting sample FIFO in the MEL front end.
- Pops 16-bit PCM samples through that FIFO's rd_en/empty interface and keeps them in a FRAME_LEN-deep circular buffer.
- Emits overlapping analysis frames, oldest sample first, on a valid/ready stream that feeds the windowing/FFT stage.
- First frame needs FRAME_LEN fresh samples; each later frame needs HOP_LEN new samples.

Parameters:
- DATA_WIDTH, 16, sample width; equals the FIFO read width.
- FRAME_LEN, 512, samples per frame; must be a power of two and at least 2.
- HOP_LEN, 128, new samples between frames; 1 <= HOP_LEN <= FRAME_LEN.
- ADDR_WIDTH, $clog2(FRAME_LEN), ring address and index width.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clr, input, 1, synchronous clear; restarts framing from an empty ring.
- fifo_empty, input, 1, FIFO empty flag.
- fifo_rd_data, input, DATA_WIDTH, FIFO head sample; valid whenever fifo_empty=0.
- fifo_rd_en, output, 1, pop request; a pop takes effect at the clock edge.
- m_valid, output, 1, frame sample valid.
- m_ready, input, 1, downstream accept.
- m_data, output, DATA_WIDTH, frame sample.
- m_index, output, ADDR_WIDTH, sample position within the frame, 0..FRAME_LEN-1.
- m_last, output, 1, high with index FRAME_LEN-1.
- frame_cnt, output, 16, frames completed; wraps modulo 2^16.

Behaviour:
- Reset and clr state:
  - state=FILL, wr_ptr=0, fill_cnt=0, need=FRAME_LEN, m_index=0, frame_cnt=0.
  - Outputs m_valid=0, m_last=0, fifo_rd_en=0.
  - Ring contents are not cleared.
- clr priority: clr has priority over every other event in the same cycle, including a pop or a handshake. No pop occurs in a cycle where clr=1.
- FILL state:
  - fifo_rd_en = (state==FILL) && !fifo_empty && !clr, combinational.
  - On each pop: ring[wr_ptr] <= fifo_rd_data; wr_ptr <= wr_ptr+1 modulo FRAME_LEN; fill_cnt <= fill_cnt+1.
  - fill_cnt is ADDR_WIDTH+1 bits wide.
  - When the pop makes fill_cnt reach need: go to EMIT, set fill_cnt=0 and need=HOP_LEN, latch base=new wr_ptr (the oldest sample).
  - fifo_empty=1 stalls FILL indefinitely with no state change.
- EMIT state:
  - m_valid=1 from the cycle after the final pop; latency is one cycle from the last pop edge.
  - m_data = ring[(base+m_index) mod FRAME_LEN], read combinationally.
  - m_last = (m_index==FRAME_LEN-1).
  - fifo_rd_en=0 throughout EMIT; there are no pops.
  - On m_valid && m_ready: m_index increments.
  - On the handshake with m_last=1: m_index=0, frame_cnt+1, return to FILL. Popping may resume the next cycle.
  - With m_ready=0: m_valid, m_data, m_index and m_last hold stable.
- Boundary cases:
  - HOP_LEN==FRAME_LEN gives back-to-back frames with no overlap.
  - HOP_LEN==1 gives a frame after every new sample.
  - Asynchronous reset mid-frame drops the partial frame; the next frame again requires FRAME_LEN samples.
- Throughput: a steady-state frame costs HOP_LEN pop cycles plus FRAME_LEN handshake cycles. There are no idle cycles between FILL and EMIT beyond those stated above.

Test Plan:
- FRAME_LEN=8, HOP_LEN=4, FIFO supplies 1,2,3,...,16 with m_ready=1 -> frame 0 data 1..8, m_index 0..7, m_last on 8; frame 1 data 5..12; frame 2 data 9..16; frame_cnt=3.
- Frame 0 m_valid timing: 8th pop at edge N -> m_valid=1 in the cycle after edge N with m_data=1; fifo_rd_en=0 for the whole frame.
- m_ready toggles 1,0,0,1 repeatedly during a frame -> no sample lost or repeated; m_data/m_index stable while m_ready=0; the 8 outputs are still in order.
- fifo_empty=1 for 20 cycles after 5 samples -> no m_valid and fill_cnt holds at 5. After 3 more samples, frame 0 emits 1..8.
- clr asserted at m_index=3 of frame 1 -> m_valid=0 next cycle, frame_cnt=0. The next frame needs 8 fresh samples 100..107 and emits 100..107.
- HOP_LEN=FRAME_LEN=8 with samples 1..16 -> frames 1..8 then 9..16. Separately, rst_n pulse mid-FILL -> all outputs 0 and need back to 8.
